// File: rtl/sram22_req_ctrl.sv
// Request/response front end for an sram22 single-port macro: valid/ready
// requests drive the macro pins, read data lands in a credit-guarded FIFO.
module sram22_req_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int WMASK_WIDTH = 1,
  parameter int FIFO_DEPTH  = 3,
  parameter int INIT_EN     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout,
  output logic                   init_done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    StInit,
    StRun
  } state_e;

  localparam state_e RESET_STATE = (INIT_EN != 0) ? StInit : StRun;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];

  logic                  fire;
  logic                  push;
  logic                  pop;
  logic [CNT_W:0]        credits_used;

  // A slot is reserved per in-flight read, so the FIFO can never overflow
  // and req_ready depends on registers only.
  always_comb begin
    credits_used = {1'b0, count_q} + {{CNT_W{1'b0}}, rd_pending_q};
    req_ready    = !rst && (state_q == StRun) &&
                   (credits_used < (CNT_W + 1)'(FIFO_DEPTH));
    fire         = req_valid && req_ready;
    rsp_valid    = (count_q != '0);
    rsp_rdata    = rsp_valid ? fifo_mem_q[rd_ptr_q] : '0;
    init_done    = (state_q == StRun);
    push         = rd_pending_q;
    pop          = rsp_valid && rsp_ready;
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    rd_pending_d = 1'b0;
    sram_we      = 1'b0;
    sram_wmask   = '0;
    sram_addr    = '0;
    sram_din     = '0;
    if (!rst) begin
      unique case (state_q)
        StInit: begin
          sram_we    = 1'b1;
          sram_wmask = '1;
          sram_addr  = init_cnt_q;
          init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
          if (init_cnt_q == '1) begin
            state_d = StRun;
          end
        end
        StRun: begin
          // Idle cycles fall through as a read of address 0, which is harmless.
          if (fire) begin
            sram_we    = req_we;
            sram_wmask = req_wmask;
            sram_addr  = req_addr;
            sram_din   = req_wdata;
          end
          rd_pending_d = fire && !req_we;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RESET_STATE;
      init_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      rd_pending_q <= rd_pending_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Macro dout is only meaningful the cycle after a read fire.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem_q[wr_ptr_q] <= sram_dout;
    end
  end

endmodule

// File: tb/tb_sram22_req_ctrl.sv
// Directed bench for sram22_req_ctrl with a behavioural sram22 macro model
// that powers up with non-zero contents.
module tb_sram22_req_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [0:0]  req_wmask;
  logic [11:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        sram_we;
  logic [0:0]  sram_wmask;
  logic [11:0] sram_addr;
  logic [7:0]  sram_din;
  logic [7:0]  sram_dout;
  logic        init_done;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] memModel [4096];
  logic [7:0] pattern  [8];

  sram22_req_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (12),
    .WMASK_WIDTH(1),
    .FIFO_DEPTH (3),
    .INIT_EN    (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_wmask (req_wmask),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .sram_we   (sram_we),
    .sram_wmask(sram_wmask),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first macro model with one cycle of read latency.
  always @(posedge clk) begin
    if (sram_we && sram_wmask[0]) begin
      memModel[sram_addr] <= sram_din;
    end
    sram_dout <= memModel[sram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic we, input logic mask,
                               input logic [11:0] addr, input logic [7:0] wdata,
                               input logic rspRdy);
    req_valid    = valid;
    req_we       = we;
    req_wmask[0] = mask;
    req_addr     = addr;
    req_wdata    = wdata;
    rsp_ready    = rspRdy;
  endtask

  task automatic runInit(input string tag);
    int weCount;
    int bad;
    int stale;
    weCount = 0;
    bad     = 0;
    stale   = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (rsp_valid) stale++;
      if (init_done) break;
      if (!(sram_we && sram_addr == weCount[11:0] && sram_din == 8'h00 &&
            sram_wmask == 1'b1 && !req_ready)) bad++;
      weCount++;
    end
    checkOutput({tag, "_we_cycles"}, 32'(weCount), 32'd4096);
    checkOutput({tag, "_bad_cycles"}, 32'(bad), 32'd0);
    checkOutput({tag, "_stale_rsp"}, 32'(stale), 32'd0);
    checkOutput({tag, "_done"}, 32'(init_done), 32'd1);
    checkOutput({tag, "_idle_we"}, 32'(sram_we), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic doWrite(input logic [11:0] addr, input logic [7:0] data,
                         input logic mask, input string tag);
    applyStimulus(1'b1, 1'b1, mask, addr, data, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_we"}, 32'(sram_we), 32'd1);
    checkOutput({tag, "_addr"}, 32'(sram_addr), 32'(addr));
    checkOutput({tag, "_din"}, 32'(sram_din), 32'(data));
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
  endtask

  task automatic doRead(input logic [11:0] addr, input logic [7:0] expData,
                        input string tag);
    int lat;
    bit seen;
    applyStimulus(1'b1, 1'b0, 1'b0, addr, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
    lat  = 1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd2);
    checkOutput({tag, "_data"}, 32'(rsp_rdata), 32'(expData));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int drops;
    int firstC;
    int lastC;
    int accepted;
    int nextIdx;
    logic rdyNow;

    for (int i = 0; i < 4096; i++) memModel[i] = 8'hEE;
    pattern = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_sram_we", 32'(sram_we), 32'd0);
    checkOutput("rst_sram_addr", 32'(sram_addr), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("rst_init_done", 32'(init_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    runInit("init");

    // Write then read-after-write to the same address, plus zero-fill checks.
    doWrite(12'h123, 8'hA5, 1'b1, "wr123");
    doRead(12'h123, 8'hA5, "rd123");
    doRead(12'h7FF, 8'h00, "rd7ff");
    doWrite(12'h010, 8'h3C, 1'b0, "wr010_nomask");
    doRead(12'h010, 8'h00, "rd010");
    doWrite(12'hFFF, 8'h5A, 1'b1, "wrfff");
    doRead(12'hFFF, 8'h5A, "rdfff");

    for (int i = 0; i < 8; i++) begin
      doWrite(12'h200 + 12'(i), pattern[i], 1'b1, "preload");
    end

    // Eight back-to-back reads with the consumer always ready.
    n      = 0;
    drops  = 0;
    firstC = -1;
    lastC  = -1;
    for (int c = 0; c < 16 && n < 8; c++) begin
      if (c < 8) applyStimulus(1'b1, 1'b0, 1'b0, 12'h200 + 12'(c), 8'h00, 1'b1);
      else       applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
      @(negedge clk);
      if (c < 8 && !req_ready) drops++;
      if (rsp_valid) begin
        checkOutput("b2b_data", 32'(rsp_rdata), 32'(pattern[n]));
        if (firstC < 0) firstC = c;
        lastC = c;
        n++;
      end
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
    checkOutput("b2b_count", 32'(n), 32'd8);
    checkOutput("b2b_drops", 32'(drops), 32'd0);
    checkOutput("b2b_first_cycle", 32'(firstC), 32'd2);
    checkOutput("b2b_span", 32'(lastC - firstC), 32'd7);

    // Backpressure: the credit rule admits exactly three reads.
    accepted = 0;
    nextIdx  = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h200 + 12'(nextIdx), 8'h00, 1'b0);
      @(negedge clk);
      rdyNow = req_ready;
      @(posedge clk); #1;
      if (rdyNow) begin
        accepted++;
        nextIdx++;
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("bp_accepted", 32'(accepted), 32'd3);
    checkOutput("bp_ready_low", 32'(req_ready), 32'd0);
    checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp_head", 32'(rsp_rdata), 32'h10);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bp_hold", 32'(rsp_rdata), 32'h10);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
    n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        checkOutput("bp_drain", 32'(rsp_rdata), 32'(pattern[n]));
        n++;
      end
      @(posedge clk); #1;
    end
    checkOutput("bp_drain_count", 32'(n), 32'd3);
    @(negedge clk);
    checkOutput("bp_ready_back", 32'(req_ready), 32'd1);
    checkOutput("bp_empty", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Reset with two responses buffered and one read still in flight.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h200 + 12'(i), 8'h00, 1'b0);
      @(negedge clk);
      checkOutput("mr_accept", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mr_buffered", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    runInit("reinit");
    doRead(12'h123, 8'h00, "rd123_rezeroed");
    doRead(12'h200, 8'h00, "rd200_rezeroed");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
